// File: rtl/afifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : afifo_rd_ctrl
//  Purpose  : Read-domain half of an asynchronous FIFO. Brings the write
//             pointer (Gray) into clkb through a two-flop synchroniser, keeps
//             the read pointer, raises the registered empty flag, drives the
//             synchronous RAM read port and registers the returned word with
//             a one-cycle valid strobe.
//  Options  : AFIFO_RD_UNDERFLOW_EN - adds the sticky underflowb output.
//  Revision : 1.0 - initial release
// ============================================================================
module afifo_rd_ctrl #(
   parameter int AW = 4,          // RAM address width, depth = 2**AW
   parameter int DW = 8           // data width
) (
   input  logic          clkb,
   input  logic          rstnb,
   // consumer side
   input  logic          rreqb,
   output logic          emptyb,
   output logic [DW-1:0] rdatb,
   output logic          rvalidb,
`ifdef AFIFO_RD_UNDERFLOW_EN
   output logic          underflowb,
`endif
   // pointer exchange with the write domain
   input  logic [AW:0]   wptr_gray_a,
   output logic [AW:0]   rptr_gray_b,
   // RAM read port
   output logic          ren,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] mem_rdata
);

   // Pointers carry one extra bit so full and empty are distinguishable
   // and the wrap lap is visible in the Gray value.
   localparam int PW = AW + 1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PW-1:0] wsync1_q;       // first synchroniser stage (metastable)
   logic [PW-1:0] wsync2_q;       // second synchroniser stage (safe to use)
   logic [PW-1:0] rbin_q;         // binary read pointer
   logic [PW-1:0] rgray_q;        // Gray read pointer, exported
   logic          emptyb_q;       // registered empty flag
   logic          rd_pipe_q;      // accept delayed by one cycle (RAM latency)
   logic [DW-1:0] rdat_q;         // output data register
   logic          rvalid_q;       // output valid strobe

   // ------------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------------
   logic          accept_d;
   logic [PW-1:0] rbin_d;
   logic [PW-1:0] rgray_d;
   logic          emptyb_d;

   // Two-flop synchroniser; nothing else samples wptr_gray_a directly.
   always_ff @(posedge clkb or negedge rstnb) begin
      if (!rstnb) begin
         wsync1_q <= '0;
         wsync2_q <= '0;
      end else begin
         wsync1_q <= wptr_gray_a;
         wsync2_q <= wsync1_q;
      end
   end

   // Accept decision, pointer increment and empty compare.
   always_comb begin
      // The registered flag gates the request, so a read can never
      // overtake the pointer comparison.
      accept_d = rreqb & ~emptyb_q;
      rbin_d   = rbin_q + {{AW{1'b0}}, accept_d};
      rgray_d  = rbin_d ^ (rbin_d >> 1);
      // Comparing the look-ahead pointer lets the last read raise the flag
      // at the same edge that consumes the entry.
      emptyb_d = (rgray_d == wsync2_q);
   end

   // Read pointer (binary and Gray) and the empty flag.
   always_ff @(posedge clkb or negedge rstnb) begin
      if (!rstnb) begin
         rbin_q   <= '0;
         rgray_q  <= '0;
         emptyb_q <= 1'b1;
      end else begin
         rbin_q   <= rbin_d;
         rgray_q  <= rgray_d;
         emptyb_q <= emptyb_d;
      end
   end

   // Track each accepted read across the one-cycle RAM latency.
   always_ff @(posedge clkb or negedge rstnb) begin
      if (!rstnb) begin
         rd_pipe_q <= 1'b0;
      end else begin
         rd_pipe_q <= accept_d;
      end
   end

   // Capture returned RAM data; the data register holds between reads.
   always_ff @(posedge clkb or negedge rstnb) begin
      if (!rstnb) begin
         rdat_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_pipe_q;
         if (rd_pipe_q) begin
            rdat_q <= mem_rdata;
         end
      end
   end

`ifdef AFIFO_RD_UNDERFLOW_EN
   logic underflow_q;

   // Sticky record of any request made while the FIFO was empty.
   always_ff @(posedge clkb or negedge rstnb) begin
      if (!rstnb) begin
         underflow_q <= 1'b0;
      end else if (rreqb && emptyb_q) begin
         underflow_q <= 1'b1;
      end
   end

   assign underflowb = underflow_q;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign emptyb      = emptyb_q;
   assign rptr_gray_b = rgray_q;
   assign rdatb       = rdat_q;
   assign rvalidb     = rvalid_q;
   assign ren         = accept_d;
   assign raddr       = rbin_q[AW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_afifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_afifo_rd_ctrl
//  Purpose  : Self-checking bench for afifo_rd_ctrl: per-cycle vector table
//             for reset and a single-word read, then hand-written sequences
//             for a wrapping burst, a second lap, underflow and reset during
//             a burst. A scoreboard queue holds the data words expected on
//             rvalidb, in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_afifo_rd_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clkb = 1'b0;
   logic          rstnb;
   logic          rreqb;
   logic          emptyb;
   logic [DW-1:0] rdatb;
   logic          rvalidb;
   logic [AW:0]   wptr_gray_a;
   logic [AW:0]   rptr_gray_b;
   logic          ren;
   logic [AW-1:0] raddr;
   logic [DW-1:0] mem_rdata;
`ifdef AFIFO_RD_UNDERFLOW_EN
   logic          underflowb;
`endif

   afifo_rd_ctrl #(.AW(AW), .DW(DW)) dut (
      .clkb        (clkb),
      .rstnb       (rstnb),
      .rreqb       (rreqb),
      .emptyb      (emptyb),
      .rdatb       (rdatb),
      .rvalidb     (rvalidb),
`ifdef AFIFO_RD_UNDERFLOW_EN
      .underflowb  (underflowb),
`endif
      .wptr_gray_a (wptr_gray_a),
      .rptr_gray_b (rptr_gray_b),
      .ren         (ren),
      .raddr       (raddr),
      .mem_rdata   (mem_rdata)
   );

   always #5 clkb = ~clkb;

   // Synchronous-read RAM model, contents written by the bench.
   logic [DW-1:0] mem [16];
   always @(posedge clkb) begin
      if (ren === 1'b1) mem_rdata <= mem[raddr];
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Scoreboard and monitor
   // ------------------------------------------------------------------------
   logic [DW-1:0] sbq [$];
   int exp_addr = 0;       // next read index the bench expects on raddr
   int rv_count = 0;
   int cyc      = 0;
   int rv_first = -1;
   int rv_last  = -1;

   always @(negedge clkb) begin
      cyc++;
      #2;
      if (rstnb === 1'b1 && ren === 1'b1) begin
         chk("raddr", {28'd0, raddr}, exp_addr % 16);
         exp_addr++;
      end
      if (rvalidb === 1'b1) begin
         rv_count++;
         if (rv_first < 0) rv_first = cyc;
         rv_last = cyc;
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rvalid_unexpected: got rdatb=%0h expected no rvalidb at %0t", rdatb, $time);
         end else begin
            chk("rdatb", {24'd0, rdatb}, {24'd0, sbq.pop_front()});
         end
      end
   end

   // Global safety net in case something stalls.
   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------------
   // Vector table: one record per clkb cycle, outputs observed before the
   // next rising edge.
   // ------------------------------------------------------------------------
   typedef struct {
      logic          rst;
      logic          rreq;
      logic [AW:0]   wp;
      logic          e_empty;
      logic          e_ren;
      logic [AW-1:0] e_raddr;
      logic          e_rvalid;
      logic [AW:0]   e_rptr;
      logic [DW-1:0] e_rdat;
   } vec_t;

   vec_t tv [9];

   task automatic wait_rv(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (rv_count < n && k < budget) begin
         @(negedge clkb);
         #3;
         k++;
      end
      chk(name, (rv_count >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic do_reset(input logic [AW:0] wp);
      @(negedge clkb);
      rstnb       = 1'b0;
      rreqb       = 1'b0;
      wptr_gray_a = wp;
      sbq.delete();
      exp_addr    = 0;
      repeat (2) @(negedge clkb);
      rstnb = 1'b1;
   endtask

   int base;

   initial begin
      rstnb       = 1'b0;
      rreqb       = 1'b1;
      wptr_gray_a = 5'b00001;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'hA5;

      //        rst  rreq  wp        empty ren raddr rvalid rptr      rdat
      tv[0] = '{1'b0, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 5'b00000, 8'h00};
      tv[1] = '{1'b0, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 5'b00000, 8'h00};
      tv[2] = '{1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 5'b00000, 8'h00};
      tv[3] = '{1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 5'b00000, 8'h00};
      tv[4] = '{1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 5'b00000, 8'h00};
      tv[5] = '{1'b1, 1'b1, 5'b00001, 1'b0, 1'b1, 4'd0, 1'b0, 5'b00000, 8'h00};
      tv[6] = '{1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 5'b00001, 8'h00};
      tv[7] = '{1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b1, 5'b00001, 8'hA5};
      tv[8] = '{1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 5'b00001, 8'hA5};

      // ---------------- reset + single word ----------------
      sbq.push_back(8'hA5);
      for (int i = 0; i < 9; i++) begin
         @(negedge clkb);
         rstnb       = tv[i].rst;
         rreqb       = tv[i].rreq;
         wptr_gray_a = tv[i].wp;
         #1;
         chk($sformatf("v%0d_emptyb", i),  {31'd0, emptyb},      {31'd0, tv[i].e_empty});
         chk($sformatf("v%0d_ren", i),     {31'd0, ren},         {31'd0, tv[i].e_ren});
         chk($sformatf("v%0d_rvalidb", i), {31'd0, rvalidb},     {31'd0, tv[i].e_rvalid});
         chk($sformatf("v%0d_rptr", i),    {27'd0, rptr_gray_b}, {27'd0, tv[i].e_rptr});
         chk($sformatf("v%0d_rdatb", i),   {24'd0, rdatb},       {24'd0, tv[i].e_rdat});
         if (tv[i].e_ren) chk($sformatf("v%0d_raddr", i), {28'd0, raddr}, {28'd0, tv[i].e_raddr});
`ifdef AFIFO_RD_UNDERFLOW_EN
         if (!tv[i].rst) chk($sformatf("v%0d_underflow", i), {31'd0, underflowb}, 32'd0);
`endif
      end
      chk("single_sb_drained", sbq.size(), 32'd0);

      // ---------------- full burst with wrap of the address ----------------
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
      do_reset(5'b11000);
      for (int i = 0; i < 16; i++) sbq.push_back(8'(i));
      rreqb    = 1'b1;
      base     = rv_count;
      rv_first = -1;
      wait_rv(base + 16, 60, "burst_complete");
      repeat (3) @(negedge clkb);
      #3;
      chk("burst_back_to_back", rv_last - rv_first, 32'd15);
      chk("burst_count", rv_count - base, 32'd16);
      chk("burst_sb_drained", sbq.size(), 32'd0);
      chk("burst_emptyb", {31'd0, emptyb}, 32'd1);
      chk("burst_rptr", {27'd0, rptr_gray_b}, 32'b11000);

      // ---------------- second lap: four more entries ----------------
      for (int i = 0; i < 4; i++) mem[i] = 8'h40 + 8'(i);
      for (int i = 0; i < 4; i++) sbq.push_back(8'h40 + 8'(i));
      base = rv_count;
      @(negedge clkb);
      wptr_gray_a = 5'b11110;
      wait_rv(base + 4, 30, "lap2_complete");
      repeat (3) @(negedge clkb);
      #3;
      chk("lap2_count", rv_count - base, 32'd4);
      chk("lap2_sb_drained", sbq.size(), 32'd0);
      chk("lap2_emptyb", {31'd0, emptyb}, 32'd1);
      chk("lap2_rptr", {27'd0, rptr_gray_b}, 32'b11110);

      // ---------------- underflow: requests on an empty FIFO ----------------
      base = rv_count;
      @(negedge clkb);
      rreqb = 1'b0;
      @(negedge clkb);
      for (int i = 0; i < 2; i++) begin
         @(negedge clkb);
         rreqb = 1'b1;
         #1;
         chk("uf_ren", {31'd0, ren}, 32'd0);
      end
      @(negedge clkb);
      rreqb = 1'b0;
      repeat (4) @(negedge clkb);
      #3;
      chk("uf_rptr", {27'd0, rptr_gray_b}, 32'b11110);
      chk("uf_emptyb", {31'd0, emptyb}, 32'd1);
      chk("uf_no_rvalid", rv_count - base, 32'd0);
`ifdef AFIFO_RD_UNDERFLOW_EN
      chk("uf_sticky", {31'd0, underflowb}, 32'd1);
`endif

      // ---------------- reset in the middle of a burst ----------------
      for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
      do_reset(5'b00000);
      @(negedge clkb);
      wptr_gray_a = 5'b01100;
      rreqb       = 1'b1;
      for (int i = 0; i < 8; i++) sbq.push_back(8'h80 + 8'(i));
      base = rv_count;
      wait_rv(base + 2, 30, "midrst_started");
      @(negedge clkb);
      #3;
      rstnb = 1'b0;
      #1;
      chk("midrst_emptyb", {31'd0, emptyb}, 32'd1);
      chk("midrst_rvalidb", {31'd0, rvalidb}, 32'd0);
      chk("midrst_rptr", {27'd0, rptr_gray_b}, 32'd0);
      chk("midrst_ren", {31'd0, ren}, 32'd0);
      chk("midrst_rdatb", {24'd0, rdatb}, 32'd0);
`ifdef AFIFO_RD_UNDERFLOW_EN
      chk("midrst_underflow", {31'd0, underflowb}, 32'd0);
`endif
      sbq.delete();
      exp_addr    = 0;
      wptr_gray_a = 5'b00000;
      base = rv_count;
      repeat (2) @(negedge clkb);
      rstnb = 1'b1;
      repeat (10) @(negedge clkb);
      #3;
      chk("midrst_no_late_rvalid", rv_count - base, 32'd0);
      chk("midrst_emptyb_after", {31'd0, emptyb}, 32'd1);
      chk("midrst_rptr_after", {27'd0, rptr_gray_b}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
